systolic_gemm_core: RTL and testbench

SYSTOLIC_GEMM_CORE -- requirements
Module: systolic_gemm_core

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_gemm_core_pe.sv | 47 ++++
 rtl/systolic_gemm_core.sv | 193 +++++++++++++++++++
 tb/tb_systolic_gemm_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic GEMM core.
package systolic_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ACC_WIDTH_DEF  = 24;
   localparam int ROWS_DEF       = 4;
   localparam int COLS_DEF       = 4;
   localparam int K_MAX_DEF      = 255;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/systolic_gemm_core_pe.sv
// One multiply-accumulate cell: forwards A right and B down, accumulates a*b.
module gemm_pe #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic                  signed_mode_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] a_o,
   output logic [DATA_WIDTH-1:0] b_o,
   output logic [ACC_WIDTH-1:0]  acc_o
);

   logic [DATA_WIDTH-1:0] a_q, b_q;
   logic [ACC_WIDTH-1:0]  acc_q;
   logic [ACC_WIDTH-1:0]  a_ext, b_ext, prod;

   // Truncating the full-width product gives the correct wrapped result for both modes.
   always_comb begin
      a_ext = signed_mode_i ? {{(ACC_WIDTH-DATA_WIDTH){a_i[DATA_WIDTH-1]}}, a_i}
                            : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a_i};
      b_ext = signed_mode_i ? {{(ACC_WIDTH-DATA_WIDTH){b_i[DATA_WIDTH-1]}}, b_i}
                            : {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b_i};
      prod  = a_ext * b_ext;
   end

   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
      end else if (en_i) begin
         a_q   <= a_i;
         b_q   <= b_i;
         acc_q <= acc_q + prod;
      end
   end

   assign a_o   = a_q;
   assign b_o   = b_q;
   assign acc_o = acc_q;

endmodule

// File: rtl/systolic_gemm_core.sv
// Output-stationary systolic GEMM: streams K beats of A columns / B rows, drains C row by row.
//  state    | meaning
//  ST_IDLE  | waiting for start; accumulators hold the last C
//  ST_LOAD  | accepting operand beats (in_ready=1)
//  ST_FLUSH | ROWS+COLS-1 zero-injection steps to finish the wavefront
//  ST_DRAIN | presenting C rows, one per out handshake
module systolic_gemm_core
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int ROWS       = ROWS_DEF,
   parameter int COLS       = COLS_DEF,
   parameter int K_MAX      = K_MAX_DEF,
   localparam int KW        = $clog2(K_MAX+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [KW-1:0]              k_len,
   input  logic                       signed_mode,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ROWS*DATA_WIDTH-1:0] in_a,
   input  logic [COLS*DATA_WIDTH-1:0] in_b,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [COLS*ACC_WIDTH-1:0]  out_data,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done
);

   localparam int FLUSH_LEN = ROWS + COLS - 1;
   localparam int CW        = max_int(KW, $clog2(FLUSH_LEN+1));
   localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [RW-1:0]   row_q, row_d;
   logic            sm_q, sm_d;
   logic            done_q, done_d;
   logic            en, clr, last_row;

   assign en       = ((state_q == ST_LOAD) && in_valid) || (state_q == ST_FLUSH);
   assign clr      = (state_q == ST_IDLE) && start;
   assign last_row = (row_q == RW'(ROWS-1));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      sm_d    = sm_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            sm_d  = signed_mode;
            row_d = '0;
            if (k_len == '0) begin
               state_d = ST_FLUSH;
               cnt_d   = CW'(FLUSH_LEN);
            end else begin
               state_d = ST_LOAD;
               cnt_d   = CW'(k_len);
            end
         end
         ST_LOAD: if (in_valid) begin
            if (cnt_q == CW'(1)) begin
               state_d = ST_FLUSH;
               cnt_d   = CW'(FLUSH_LEN);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FLUSH: begin
            if (cnt_q == CW'(1)) begin
               state_d = ST_DRAIN;
               row_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_DRAIN: if (out_ready) begin
            if (last_row) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               row_d = row_q + RW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         sm_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         sm_q    <= sm_d;
         done_q  <= done_d;
      end
   end

   logic [DATA_WIDTH-1:0] a_sk [ROWS];
   logic [DATA_WIDTH-1:0] b_sk [COLS];
   logic [DATA_WIDTH-1:0] a_w  [ROWS][COLS+1];
   logic [DATA_WIDTH-1:0] b_w  [ROWS+1][COLS];
   logic [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];

   // Row r of A enters r steps late, column c of B c steps late, so matching k meet in PE(r,c).
   for (genvar gr = 0; gr < ROWS; gr++) begin : g_askew
      logic [DATA_WIDTH-1:0] src;
      assign src = (state_q == ST_LOAD) ? in_a[gr*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gr == 0) begin : g_pass
         assign a_sk[gr] = src;
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr_q [gr];
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               for (int i = 0; i < gr; i++) sr_q[i] <= '0;
            end else if (en) begin
               sr_q[0] <= src;
               for (int i = 1; i < gr; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign a_sk[gr] = sr_q[gr-1];
      end
      assign a_w[gr][0] = a_sk[gr];
   end

   for (genvar gc = 0; gc < COLS; gc++) begin : g_bskew
      logic [DATA_WIDTH-1:0] src;
      assign src = (state_q == ST_LOAD) ? in_b[gc*DATA_WIDTH +: DATA_WIDTH] : '0;
      if (gc == 0) begin : g_pass
         assign b_sk[gc] = src;
      end else begin : g_dly
         logic [DATA_WIDTH-1:0] sr_q [gc];
         always_ff @(posedge clk) begin
            if (rst || clr) begin
               for (int i = 0; i < gc; i++) sr_q[i] <= '0;
            end else if (en) begin
               sr_q[0] <= src;
               for (int i = 1; i < gc; i++) sr_q[i] <= sr_q[i-1];
            end
         end
         assign b_sk[gc] = sr_q[gc-1];
      end
      assign b_w[0][gc] = b_sk[gc];
   end

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gc = 0; gc < COLS; gc++) begin : g_col
         gemm_pe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_pe (
            .clk          (clk),
            .rst          (rst),
            .en_i         (en),
            .clr_i        (clr),
            .signed_mode_i(sm_q),
            .a_i          (a_w[gr][gc]),
            .b_i          (b_w[gr][gc]),
            .a_o          (a_w[gr][gc+1]),
            .b_o          (b_w[gr+1][gc]),
            .acc_o        (acc_w[gr][gc])
         );
      end
   end

   logic [COLS*ACC_WIDTH-1:0] row_data;

   always_comb begin
      row_data = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == RW'(r)) begin
            for (int c = 0; c < COLS; c++) row_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[r][c];
         end
      end
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_DRAIN);
   assign out_last  = out_valid && last_row;
   assign out_data  = out_valid ? row_data : '0;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_systolic_gemm_core.sv
// Directed + randomized bench for a 2x2 systolic GEMM core against a plain matrix-product model.
module tb_systolic_gemm_core;

   localparam int DW = 8;
   localparam int AW = 24;
   localparam int R  = 2;
   localparam int C  = 2;
   localparam int KW = 8;

   logic           clk = 1'b0;
   logic           rst, start, signed_mode, in_valid, out_ready;
   logic [KW-1:0]  k_len;
   logic [R*DW-1:0] in_a;
   logic [C*DW-1:0] in_b;
   logic           in_ready, out_valid, out_last, busy, done;
   logic [C*AW-1:0] out_data;

   int total = 0;
   int bad   = 0;

   logic [7:0] ma [R][16];
   logic [7:0] mb [16][C];

   systolic_gemm_core #(
      .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(R), .COLS(C), .K_MAX(255)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint ext(input logic [7:0] v, input bit sm);
      return sm ? longint'($signed(v)) : longint'(v);
   endfunction

   function automatic logic [AW-1:0] model_c(input int k, input bit sm, input int r, input int c);
      longint s = 0;
      for (int kk = 0; kk < k; kk++) s += ext(ma[r][kk], sm) * ext(mb[kk][c], sm);
      return AW'(s);
   endfunction

   task automatic fill_rand(input int k);
      for (int kk = 0; kk < k; kk++) begin
         for (int r = 0; r < R; r++) ma[r][kk] = 8'($urandom);
         for (int c = 0; c < C; c++) mb[kk][c] = 8'($urandom);
      end
   endtask

   task automatic fill_const(input int k, input logic [7:0] v);
      for (int kk = 0; kk < k; kk++) begin
         for (int r = 0; r < R; r++) ma[r][kk] = v;
         for (int c = 0; c < C; c++) mb[kk][c] = v;
      end
   endtask

   task automatic run_job(input int k, input bit sm, input bit bubbles, input int stall, input bit poke);
      int i, g, w, r;
      bit tog, hs;
      logic [C*AW-1:0] held;
      logic [C*AW-1:0] exp_row;
      @(negedge clk);
      start = 1'b1; k_len = KW'(k); signed_mode = sm;
      @(negedge clk);
      start = 1'b0; signed_mode = ~sm;
      chk("busy_after_start", 64'(busy), 64'(1));
      chk("in_ready_after_start", 64'(in_ready), 64'(k != 0));
      i = 0; g = 0; tog = 1'b1;
      while (i < k && g < 200) begin
         in_valid = bubbles ? tog : 1'b1;
         tog = ~tog;
         if (in_valid) begin
            in_a = {ma[1][i], ma[0][i]};
            in_b = {mb[i][1], mb[i][0]};
         end else begin
            in_a = R*DW'($urandom);
            in_b = C*DW'($urandom);
         end
         hs = in_valid && in_ready;
         @(negedge clk);
         if (hs) i++;
         g++;
      end
      in_valid = 1'b0;
      chk("load_beats", 64'(i), 64'(k));
      w = 0;
      while (!out_valid && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("flush_len", 64'(w), 64'(R + C - 1));
      r = 0; g = 0;
      while (r < R && g < 50) begin
         exp_row = {model_c(k, sm, r, 1), model_c(k, sm, r, 0)};
         chk("beat_valid", 64'(out_valid), 64'(1));
         chk("beat_data", 64'(out_data), 64'(exp_row));
         chk("beat_last", 64'(out_last), 64'(r == R - 1));
         if (r == 0 && stall > 0) begin
            out_ready = 1'b0;
            held = out_data;
            repeat (stall) begin
               @(negedge clk);
               chk("stall_data", 64'(out_data), 64'(held));
               chk("stall_valid", 64'(out_valid), 64'(1));
               chk("stall_last", 64'(out_last), 64'(0));
            end
         end
         if (r == 0 && poke) start = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         start = 1'b0;
         out_ready = 1'b0;
         r++;
         g++;
      end
      chk("done_pulse", 64'(done), 64'(1));
      chk("idle_out_valid", 64'(out_valid), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      rst = 1'b0;

      ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
      mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
      run_job(2, 1'b1, 1'b0, 0, 1'b0);
      run_job(2, 1'b1, 1'b1, 5, 1'b0);

      fill_const(4, 8'h80);
      run_job(4, 1'b1, 1'b0, 0, 1'b0);
      fill_const(4, 8'hFF);
      run_job(4, 1'b0, 1'b0, 0, 1'b0);

      run_job(0, 1'b1, 1'b0, 0, 1'b0);

      fill_rand(2);
      @(negedge clk);
      start = 1'b1; k_len = KW'(2); signed_mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; in_a = {ma[1][0], ma[0][0]}; in_b = {mb[0][1], mb[0][0]};
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'(0));
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_out_last", 64'(out_last), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      chk("midrst_out_data", 64'(out_data), 64'(0));
      rst = 1'b0;
      fill_rand(3);
      run_job(3, 1'b0, 1'b0, 0, 1'b0);

      fill_rand(2);
      run_job(2, 1'b1, 1'b0, 2, 1'b1);

      for (int j = 0; j < 6; j++) begin
         int k;
         k = int'($urandom_range(1, 8));
         fill_rand(k);
         run_job(k, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
